// File: rtl/dram_arbiter.sv
// Round-robin, burst-capped arbiter sharing one single-port data RAM between core (r0) and loader (r1).
// Latency: grant same cycle, read data 1 cycle after the grant edge; backpressure: req is held until gnt.
module dram_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q
);

  localparam logic [3:0] BURST_CAP = 4'(MAX_BURST - 1);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  acc_t       acc0, acc1, win_acc;
  logic       owner;
  logic       idle;
  logic [3:0] burst_cnt;
  logic [1:0] rd_pend;
  logic       any_gnt;
  logic       win;

  assign acc0 = {r0_we, r0_addr, r0_wdata};
  assign acc1 = {r1_we, r1_addr, r1_wdata};

  // Under contention the owner keeps the RAM until its run hits the cap;
  // after an idle cycle the non-owner goes first so a fresh run starts fairly.
  always_comb begin
    any_gnt = 1'b0;
    win     = 1'b0;
    if (rst) begin
      if (r0_req && !r1_req) begin
        any_gnt = 1'b1;
        win     = 1'b0;
      end else if (r1_req && !r0_req) begin
        any_gnt = 1'b1;
        win     = 1'b1;
      end else if (r0_req && r1_req) begin
        any_gnt = 1'b1;
        if (!idle && (burst_cnt < BURST_CAP)) win = owner;
        else                                  win = !owner;
      end
    end
  end

  assign r0_gnt  = any_gnt && !win;
  assign r1_gnt  = any_gnt && win;
  assign win_acc = win ? acc1 : acc0;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    if (any_gnt) begin
      mem_addr  = win_acc.addr;
      mem_wdata = win_acc.wdata;
      mem_wren  = win_acc.we;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      owner     <= 1'b1;
      idle      <= 1'b1;
      burst_cnt <= '0;
      rd_pend   <= '0;
    end else begin
      rd_pend <= {r1_gnt && !r1_we, r0_gnt && !r0_we};
      if (any_gnt) begin
        idle <= 1'b0;
        if (win == owner) begin
          if (burst_cnt < BURST_CAP) burst_cnt <= burst_cnt + 4'd1;
        end else begin
          owner     <= win;
          burst_cnt <= '0;
        end
      end else begin
        idle      <= 1'b1;
        burst_cnt <= '0;
      end
    end
  end

  // RAM read data lands one cycle after the address edge, aligned with rd_pend.
  assign r0_rvalid = rd_pend[0];
  assign r1_rvalid = rd_pend[1];
  assign r0_rdata  = mem_q;
  assign r1_rdata  = mem_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a behavioural RAM and per-port read-data scoreboard.
module tb_dram_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          rst = 1'b0;
  logic          r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wren;
  logic [DW-1:0] mem_q;

  bit [DW-1:0] ram     [256];
  bit [DW-1:0] ref_mem [256];
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  int vectors = 0;
  int miscompares = 0;

  dram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
    .CLK(CLK), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 CLK = ~CLK;

  // Single-port RAM, read-before-write, one-cycle read latency; preloaded while in reset.
  always @(posedge CLK) begin
    if (!rst) begin
      ram[8'h11] <= 8'h3C;
      ram[8'h20] <= 8'h5A;
    end else if (mem_wren) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_q <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check grants, RAM port and due read data, then schedule new expectations.
  task automatic cyc(input bit e0, input bit e1);
    @(negedge CLK);
    chk("r0_gnt", {31'd0, r0_gnt}, {31'd0, e0});
    chk("r1_gnt", {31'd0, r1_gnt}, {31'd0, e1});
    chk("r0_rvalid", {31'd0, r0_rvalid}, {31'd0, q0.size() != 0});
    if (q0.size() != 0) chk("r0_rdata", {24'd0, r0_rdata}, {24'd0, q0.pop_front()});
    chk("r1_rvalid", {31'd0, r1_rvalid}, {31'd0, q1.size() != 0});
    if (q1.size() != 0) chk("r1_rdata", {24'd0, r1_rdata}, {24'd0, q1.pop_front()});
    if (e0) begin
      chk("mem_addr0", {24'd0, mem_addr}, {24'd0, r0_addr});
      chk("mem_wren0", {31'd0, mem_wren}, {31'd0, r0_we});
      if (r0_we) begin
        chk("mem_wdata0", {24'd0, mem_wdata}, {24'd0, r0_wdata});
        ref_mem[r0_addr] = r0_wdata;
      end else q0.push_back(ref_mem[r0_addr]);
    end else if (e1) begin
      chk("mem_addr1", {24'd0, mem_addr}, {24'd0, r1_addr});
      chk("mem_wren1", {31'd0, mem_wren}, {31'd0, r1_we});
      if (r1_we) begin
        chk("mem_wdata1", {24'd0, mem_wdata}, {24'd0, r1_wdata});
        ref_mem[r1_addr] = r1_wdata;
      end else q1.push_back(ref_mem[r1_addr]);
    end else begin
      chk("mem_wren_idle", {31'd0, mem_wren}, 32'd0);
      chk("mem_addr_idle", {24'd0, mem_addr}, 32'd0);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    ref_mem[8'h11] = 8'h3C;
    ref_mem[8'h20] = 8'h5A;

    // Reset held with both ports requesting
    repeat (2) @(posedge CLK);
    #1;
    r0_req = 1'b1; r0_addr = 8'h00;
    r1_req = 1'b1; r1_addr = 8'h01;
    @(negedge CLK);
    chk("rst_r0_gnt", {31'd0, r0_gnt}, 32'd0);
    chk("rst_r1_gnt", {31'd0, r1_gnt}, 32'd0);
    chk("rst_mem_wren", {31'd0, mem_wren}, 32'd0);
    chk("rst_r0_rvalid", {31'd0, r0_rvalid}, 32'd0);
    chk("rst_r1_rvalid", {31'd0, r1_rvalid}, 32'd0);
    @(posedge CLK);
    #1;
    rst = 1'b1;
    cyc(1'b1, 1'b0);
    r0_req = 1'b0; r1_req = 1'b0;
    cyc(1'b0, 1'b0);

    // r0 streaming: write 0x10, read it back, read preloaded 0x11
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'h10; r0_wdata = 8'hA5;
    cyc(1'b1, 1'b0);
    r0_we = 1'b0;
    cyc(1'b1, 1'b0);
    r0_addr = 8'h11;
    cyc(1'b1, 1'b0);
    r0_req = 1'b0;
    cyc(1'b0, 1'b0);

    // r1 runs two accesses, idles one cycle, then both contend for 16 cycles
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h20;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    r1_req = 1'b0;
    cyc(1'b0, 1'b0);
    r0_req = 1'b1; r0_addr = 8'h11;
    r1_req = 1'b1; r1_addr = 8'h10;
    for (int i = 0; i < 16; i++) begin
      cyc(((i / 4) % 2) == 0, ((i / 4) % 2) == 1);
    end
    r0_req = 1'b0; r1_req = 1'b0;
    cyc(1'b0, 1'b0);

    // Reset lands while an r1 read is in flight
    r1_req = 1'b1; r1_addr = 8'h20;
    cyc(1'b0, 1'b1);
    r1_req = 1'b0;
    rst = 1'b0;
    q1.delete();
    #1;
    chk("rst_drop_r1_rvalid", {31'd0, r1_rvalid}, 32'd0);
    @(posedge CLK);
    #1;
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    r1_req = 1'b1;
    cyc(1'b0, 1'b1);
    r1_req = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
